fpmult_issue_arbiter: RTL and testbench

- Shares one fixed-latency FP multiplier datapath between two requesters. The datapath is the prepare/exponent-sign/multiply/normalize/round chain.
- Round-robin arbitration, one issue per cycle max.
- Tracks the owner of every in-flight operation and steers results back to the owner.
- Provides a drain state so software/FSMs can quiesce the multiplier before reconfiguration or shutdown.

---
 rtl/fpmult_pkg.sv | 22 ++
 rtl/fpmult_issue_arbiter_if.sv | 47 ++++
 rtl/fpmult_tag_pipe.sv | 50 +++++
 rtl/fpmult_issue_arbiter.sv | 158 +++++++++++++++
 tb/tb_fpmult_issue_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpmult_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpmult_pkg
// Brief   : Shared types and constants for the FP multiplier issue slice.
// Rev     : 1.0  initial release
// ============================================================================
package fpmult_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } arb_state_t;

    localparam int c_TAG_W    = 1;
    localparam int c_FP_W     = 32;
    localparam int c_EXP_BIAS = 127;

    localparam logic [c_TAG_W-1:0] c_OWNER_REQ0 = 1'b0;
    localparam logic [c_TAG_W-1:0] c_OWNER_REQ1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fpmult_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : fpmult_issue_arbiter_if
// Brief   : Requester, datapath, response and drain signals of the arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface fpmult_issue_arbiter_if
    import fpmult_pkg::*;
#(
    parameter int W = c_FP_W
);
    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic         mul_valid;
    logic [W-1:0] mul_p;
    logic         rsp0_valid;
    logic         rsp1_valid;
    logic [W-1:0] rsp_p;
    logic         drain_req;
    logic         drained;
    logic         busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               mul_p, drain_req,
        output req0_ready, req1_ready, mul_a, mul_b, mul_valid,
               rsp0_valid, rsp1_valid, rsp_p, drained, busy
    );

    // Requesters plus datapath side
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               mul_p, drain_req,
        input  req0_ready, req1_ready, mul_a, mul_b, mul_valid,
               rsp0_valid, rsp1_valid, rsp_p, drained, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpmult_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fpmult_tag_pipe
// Brief   : LAT-deep {valid, owner} shift register with OR-reduced busy.
// Rev     : 1.0  initial release
// ============================================================================
module fpmult_tag_pipe
    import fpmult_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [c_TAG_W-1:0] i_owner,
    output logic               o_valid,
    output logic [c_TAG_W-1:0] o_owner,
    output logic               o_busy
);
    logic [LAT-1:0]              r_valid;
    logic [LAT-1:0][c_TAG_W-1:0] r_owner;

    if (LAT == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= '0;
                r_owner <= '0;
            end else begin
                r_valid <= i_valid;
                r_owner <= i_owner;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= '0;
                r_owner <= '0;
            end else begin
                r_valid <= {r_valid[LAT-2:0], i_valid};
                r_owner <= {r_owner[LAT-2:0], i_owner};
            end
        end
    end

    assign o_valid = r_valid[LAT-1];
    assign o_owner = r_owner[LAT-1];
    assign o_busy  = |r_valid;

endmodule
`default_nettype wire

// File: rtl/fpmult_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fpmult_issue_arbiter
// Brief   : Round-robin issue of two requesters onto one fixed-latency FP
//           multiplier, with owner-tagged response steering and a drain mode.
//           FPMULT_ARB_STATS_EN adds saturating per-requester grant counters.
// Rev     : 1.0  initial release
// ============================================================================
module fpmult_issue_arbiter
    import fpmult_pkg::*;
#(
    parameter int LAT = 4,
    parameter int W   = c_FP_W
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef FPMULT_ARB_STATS_EN
    output logic [15:0]           grant0_cnt,
    output logic [15:0]           grant1_cnt,
`endif
    fpmult_issue_arbiter_if.slave bus
);
    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic               w_grant0;
    logic               w_grant1;
    logic               r_rr_ptr;
    logic               r_mul_valid;
    logic [c_TAG_W-1:0] r_mul_owner;
    logic [W-1:0]       r_mul_a;
    logic [W-1:0]       r_mul_b;
    logic               w_tail_valid;
    logic [c_TAG_W-1:0] w_tail_owner;
    logic               w_pipe_busy;
    logic               w_busy;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic [W-1:0]       r_rsp_p;
    logic               r_drained;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants are suppressed in the very cycle drain_req arrives.
    always_comb begin
        w_state_next = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            ST_RUN:   if (bus.drain_req)  w_state_next = ST_DRAIN;
            ST_DRAIN: if (!bus.drain_req) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
        if (r_state == ST_RUN && !bus.drain_req) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = ~r_rr_ptr;
                w_grant1 = r_rr_ptr;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_valid <= 1'b0;
            r_mul_owner <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rr_ptr    <= 1'b0;
        end else begin
            r_mul_valid <= w_grant0 | w_grant1;
            if (w_grant1) begin
                r_mul_a     <= bus.req1_a;
                r_mul_b     <= bus.req1_b;
                r_mul_owner <= c_OWNER_REQ1;
                r_rr_ptr    <= 1'b0;
            end else if (w_grant0) begin
                r_mul_a     <= bus.req0_a;
                r_mul_b     <= bus.req0_b;
                r_mul_owner <= c_OWNER_REQ0;
                r_rr_ptr    <= 1'b1;
            end
        end
    end

    // Fed from the issue stage so the tail lines up with mul_p.
    fpmult_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_mul_valid),
        .i_owner (r_mul_owner),
        .o_valid (w_tail_valid),
        .o_owner (w_tail_owner),
        .o_busy  (w_pipe_busy)
    );

    assign w_busy = r_mul_valid | w_pipe_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_p      <= '0;
            r_drained    <= 1'b0;
        end else begin
            r_rsp0_valid <= w_tail_valid && (w_tail_owner == c_OWNER_REQ0);
            r_rsp1_valid <= w_tail_valid && (w_tail_owner == c_OWNER_REQ1);
            if (w_tail_valid) begin
                r_rsp_p <= bus.mul_p;
            end
            r_drained <= (w_state_next == ST_DRAIN) && !w_busy;
        end
    end

`ifdef FPMULT_ARB_STATS_EN
    logic [15:0] r_grant0_cnt;
    logic [15:0] r_grant1_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
        end else begin
            if (w_grant0 && r_grant0_cnt != 16'hFFFF) begin
                r_grant0_cnt <= r_grant0_cnt + 16'd1;
            end
            if (w_grant1 && r_grant1_cnt != 16'hFFFF) begin
                r_grant1_cnt <= r_grant1_cnt + 16'd1;
            end
        end
    end

    assign grant0_cnt = r_grant0_cnt;
    assign grant1_cnt = r_grant1_cnt;
`endif

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.mul_valid  = r_mul_valid;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp_p      = r_rsp_p;
    assign bus.drained    = r_drained;
    assign bus.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fpmult_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpmult_issue_arbiter
// Brief   : Self-checking bench with a LAT-cycle FP multiply model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fpmult_issue_arbiter;
    import fpmult_pkg::*;

    localparam int LAT = 4;
    localparam int W   = 32;

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    typedef struct {
        logic [31:0] p;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpmult_issue_arbiter_if #(.W(W)) bus ();

`ifdef FPMULT_ARB_STATS_EN
    logic [15:0] grant0_cnt;
    logic [15:0] grant1_cnt;
`endif

    fpmult_issue_arbiter #(
        .LAT (LAT),
        .W   (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FPMULT_ARB_STATS_EN
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt),
`endif
        .bus        (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int cycle     = 0;
    int rsp_count = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e;
    logic [31:0] cur_exp0;
    logic [31:0] cur_exp1;
    vec_t vecs [6];
    logic [31:0] ops [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] p0  [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    logic [31:0] p1  [4] = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000};

    // Truncating multiply, exact for the normal operands used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  ex;
        logic        s;
        s  = a[31] ^ b[31];
        m  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        ex = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) begin
            ex = ex + 10'd1;
            return {s, ex[7:0], m[46:24]};
        end
        return {s, ex[7:0], m[45:23]};
    endfunction

    logic [31:0] dp_p [LAT];
    always @(posedge clk) begin
        dp_p[0] <= fmul(bus.mul_a, bus.mul_b);
        for (int k = 1; k < LAT; k++) dp_p[k] <= dp_p[k-1];
    end
    assign bus.mul_p = dp_p[LAT-1];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb0.delete();
        sb1.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard: push on accepted handshakes, pop on responses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready) sb0.push_back('{cur_exp0, cycle});
            if (bus.req1_valid && bus.req1_ready) sb1.push_back('{cur_exp1, cycle});
        end
        if (bus.rsp0_valid && bus.rsp1_valid) begin
            checks++;
            failures++;
            $display("FAIL rsp_onehot: got both rsp valids expected at most one");
        end
        if (bus.rsp0_valid) begin
            rsp_count++;
            if (sb0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp0_unexpected: got %h expected no response", bus.rsp_p);
            end else begin
                e = sb0.pop_front();
                check("rsp0_data", bus.rsp_p, e.p);
                check("rsp0_latency", 32'(cycle - e.cyc), 32'(LAT + 2));
            end
        end
        if (bus.rsp1_valid) begin
            rsp_count++;
            if (sb1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp1_unexpected: got %h expected no response", bus.rsp_p);
            end else begin
                e = sb1.pop_front();
                check("rsp1_data", bus.rsp_p, e.p);
                check("rsp1_latency", 32'(cycle - e.cyc), 32'(LAT + 2));
            end
        end
    end

    initial begin
        int k0;
        int k1;
        int rc;
        vecs[0] = '{1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000};
        vecs[1] = '{1'b1, 32'h40400000, 32'h3F000000, 32'h3FC00000};
        vecs[2] = '{1'b0, 32'hC0000000, 32'h3FC00000, 32'hC0400000};
        vecs[3] = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[4] = '{1'b1, 32'h40000000, 32'h40000000, 32'h40800000};
        vecs[5] = '{1'b0, 32'h41200000, 32'h40A00000, 32'h42480000};

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.drain_req  = 1'b0;
        cur_exp0 = '0;
        cur_exp1 = '0;
        repeat (3) step();
        #1;
        check_bit("rst_mul_valid", bus.mul_valid, 1'b0);
        check_bit("rst_rsp0", bus.rsp0_valid, 1'b0);
        check_bit("rst_rsp1", bus.rsp1_valid, 1'b0);
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_drained", bus.drained, 1'b0);
        check("rst_rsp_p", bus.rsp_p, 32'h0);
        check("rst_mul_a", bus.mul_a, 32'h0);
        rst = 1'b0;
        step();

        // Isolated single requests
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].sel) begin
                bus.req1_valid = 1'b1; bus.req1_a = vecs[i].a; bus.req1_b = vecs[i].b;
                cur_exp1 = vecs[i].p;
            end else begin
                bus.req0_valid = 1'b1; bus.req0_a = vecs[i].a; bus.req0_b = vecs[i].b;
                cur_exp0 = vecs[i].p;
            end
            #1;
            check_bit("vec_ready0", bus.req0_ready, !vecs[i].sel);
            check_bit("vec_ready1", bus.req1_ready, vecs[i].sel);
            step();
            drop_reqs();
            repeat (LAT + 3) step();
            check("vec_rsp_hold", bus.rsp_p, vecs[i].p);
        end

        // Continuous contention after reset
        do_reset();
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req0_valid = 1'b1; bus.req0_a = ops[k0 % 4]; bus.req0_b = 32'h40000000;
            cur_exp0 = p0[k0 % 4];
            bus.req1_valid = 1'b1; bus.req1_a = ops[k1 % 4]; bus.req1_b = 32'h3F000000;
            cur_exp1 = p1[k1 % 4];
            #1;
            check_bit("cont_ready0", bus.req0_ready, (i % 2) == 0);
            check_bit("cont_ready1", bus.req1_ready, (i % 2) == 1);
            if (bus.req0_ready) k0++;
            if (bus.req1_ready) k1++;
            step();
        end
        drop_reqs();
        repeat (LAT + 4) step();
        check("cont_sb_empty", 32'(sb0.size() + sb1.size()), 32'd0);

        // Drain with three ops in flight
        for (int i = 0; i < 3; i++) begin
            bus.req0_valid = 1'b1; bus.req0_a = ops[i]; bus.req0_b = 32'h40000000;
            cur_exp0 = p0[i];
            #1;
            check_bit("drain_pre_ready0", bus.req0_ready, 1'b1);
            step();
        end
        bus.drain_req = 1'b1;
        bus.req0_a = ops[3]; cur_exp0 = p0[3];
        bus.req1_valid = 1'b1; bus.req1_a = ops[1]; bus.req1_b = 32'h3F000000;
        cur_exp1 = p1[1];
        for (int d = 0; d < 8; d++) begin
            #1;
            check_bit("drain_ready0", bus.req0_ready, 1'b0);
            check_bit("drain_ready1", bus.req1_ready, 1'b0);
            check_bit("drain_drained", bus.drained, d >= 6);
            if (d == 0) check_bit("drain_busy", bus.busy, 1'b1);
            step();
        end
        bus.drain_req  = 1'b0;
        bus.req0_valid = 1'b0;
        #1;
        check_bit("undrain_ready1_wait", bus.req1_ready, 1'b0);
        check_bit("undrain_drained_hold", bus.drained, 1'b1);
        step();
        #1;
        check_bit("undrain_ready1", bus.req1_ready, 1'b1);
        check_bit("undrain_drained_low", bus.drained, 1'b0);
        step();
        drop_reqs();
        repeat (LAT + 4) step();

        // Reset with two ops in flight
        bus.req1_valid = 1'b1; bus.req1_a = ops[2]; bus.req1_b = 32'h3F000000;
        cur_exp1 = p1[2];
        #1;
        check_bit("rmid_ready1", bus.req1_ready, 1'b1);
        step();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = ops[2]; bus.req0_b = 32'h40000000;
        cur_exp0 = p0[2];
        step();
        drop_reqs();
        step();
        rc = rsp_count;
        rst = 1'b1;
        sb0.delete();
        sb1.delete();
        step();
        rst = 1'b0;
        #1;
        check_bit("rmid_busy", bus.busy, 1'b0);
        check_bit("rmid_mul_valid", bus.mul_valid, 1'b0);
        repeat (10) step();
        check("rmid_no_rsp", 32'(rsp_count - rc), 32'd0);
        bus.req0_valid = 1'b1; bus.req0_a = ops[1]; bus.req0_b = 32'h40000000; cur_exp0 = p0[1];
        bus.req1_valid = 1'b1; bus.req1_a = ops[1]; bus.req1_b = 32'h3F000000; cur_exp1 = p1[1];
        #1;
        check_bit("rmid_ptr_ready0", bus.req0_ready, 1'b1);
        check_bit("rmid_ptr_ready1", bus.req1_ready, 1'b0);
        step();
        drop_reqs();
        repeat (LAT + 4) step();

        // Pointer holds across idle cycles
        bus.req1_valid = 1'b1; bus.req1_a = ops[3]; bus.req1_b = 32'h3F000000; cur_exp1 = p1[3];
        #1;
        check_bit("idle_ready1", bus.req1_ready, 1'b1);
        step();
        drop_reqs();
        repeat (5) step();
        bus.req0_valid = 1'b1; bus.req0_a = ops[0]; bus.req0_b = 32'h40000000; cur_exp0 = p0[0];
        bus.req1_valid = 1'b1; bus.req1_a = ops[0]; bus.req1_b = 32'h3F000000; cur_exp1 = p1[0];
        #1;
        check_bit("idle_ready0_first", bus.req0_ready, 1'b1);
        check_bit("idle_ready1_wait", bus.req1_ready, 1'b0);
        step();
        bus.req0_valid = 1'b0;
        #1;
        check_bit("idle_ready1_next", bus.req1_ready, 1'b1);
        step();
        drop_reqs();
        repeat (LAT + 4) step();

`ifdef FPMULT_ARB_STATS_EN
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = ops[0]; bus.req0_b = 32'h40000000; cur_exp0 = p0[0];
        repeat (70000) step();
        drop_reqs();
        #1;
        check("stats_grant0", {16'd0, grant0_cnt}, 32'h0000FFFF);
        check("stats_grant1", {16'd0, grant1_cnt}, 32'h00000000);
        repeat (LAT + 4) step();
`endif

        for (int t = 0; t < 50 && (sb0.size() + sb1.size()) != 0; t++) step();
        check("final_sb_empty", 32'(sb0.size() + sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
